// File: rtl/stream_stats_if.sv
// rtl/stream_stats_if.sv - sample-in / statistics-out handshake bundle for stream_stats
//
// Purpose: groups the sample input channel and the frame-result output channel.
// Ports (signals):
//   in_valid / in_ready / in_data : sample handshake, signed W-bit samples
//   out_valid / out_ready         : frame result handshake
//   out_min / out_max / out_mean  : signed W-bit frame min, max, floor mean
//   out_var                       : unsigned 2W-bit floor population variance
// Modports: master = sample source / result consumer, slave = stream_stats.
interface stream_stats_if #(
  parameter int W        = 16,
  parameter int LOG2_LEN = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [W-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [W-1:0]   out_min;
  logic signed [W-1:0]   out_max;
  logic signed [W-1:0]   out_mean;
  logic [2*W-1:0]        out_var;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_mean, out_var
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_min, out_max, out_mean, out_var
  );
endinterface

// File: rtl/stream_stats.sv
// rtl/stream_stats.sv - framed streaming min/max/mean/variance unit
//
// Purpose: accepts 2^LOG2_LEN signed samples per frame, then produces min, max,
// floor mean and exact floor population variance, held until consumed.
// Ports:
//   clk   : clock, all state on rising edge
//   rst   : asynchronous active-high reset
//   clear : synchronous frame abort (results hold, accumulators restart)
//   s     : stream_stats_if.slave (sample in, statistics out)
module stream_stats #(
  parameter int W        = 16,
  parameter int LOG2_LEN = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  stream_stats_if.slave s
);

  localparam int SW = W + LOG2_LEN;          // running sum width
  localparam int QW = 2 * W + LOG2_LEN;      // running sum of squares width
  localparam int PW = 2 * W + 2 * LOG2_LEN;  // squared-sum width

  localparam logic signed [W-1:0] MIN_INIT = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MAX_INIT = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_ACC, S_SQ, S_VAR, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [LOG2_LEN-1:0]   cnt_q, cnt_d;
  logic signed [SW-1:0]  sum_q, sum_d;
  logic [QW-1:0]         sumsq_q, sumsq_d;
  logic signed [W-1:0]   run_min_q, run_min_d;
  logic signed [W-1:0]   run_max_q, run_max_d;
  logic [PW-1:0]         sq_q, sq_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [W-1:0]   res_min_q, res_min_d;
  logic signed [W-1:0]   res_max_q, res_max_d;
  logic signed [W-1:0]   res_mean_q, res_mean_d;
  logic [2*W-1:0]        res_var_q, res_var_d;

  logic signed [W-1:0]   x;
  logic signed [2*W-1:0] x_ext;
  logic [2*W-1:0]        x_sq;
  logic signed [PW-1:0]  sum_ext;
  logic [PW-1:0]         diff;

  assign x       = s.in_data;
  assign x_ext   = (2*W)'(x);
  // x*x is never negative, so the signed product reinterprets cleanly
  assign x_sq    = $unsigned(x_ext * x_ext);
  assign sum_ext = PW'(sum_q);
  // LEN*sumsq - sum^2 is LEN^2 times the population variance, always >= 0
  assign diff    = {sumsq_q, {LOG2_LEN{1'b0}}} - sq_q;

  assign s.in_ready  = (state_q == S_ACC);
  assign s.out_valid = out_valid_q;
  assign s.out_min   = res_min_q;
  assign s.out_max   = res_max_q;
  assign s.out_mean  = res_mean_q;
  assign s.out_var   = res_var_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ACC;
      cnt_q       <= '0;
      sum_q       <= '0;
      sumsq_q     <= '0;
      run_min_q   <= MIN_INIT;
      run_max_q   <= MAX_INIT;
      sq_q        <= '0;
      out_valid_q <= 1'b0;
      res_min_q   <= '0;
      res_max_q   <= '0;
      res_mean_q  <= '0;
      res_var_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      sumsq_q     <= sumsq_d;
      run_min_q   <= run_min_d;
      run_max_q   <= run_max_d;
      sq_q        <= sq_d;
      out_valid_q <= out_valid_d;
      res_min_q   <= res_min_d;
      res_max_q   <= res_max_d;
      res_mean_q  <= res_mean_d;
      res_var_q   <= res_var_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    sumsq_d     = sumsq_q;
    run_min_d   = run_min_q;
    run_max_d   = run_max_q;
    sq_d        = sq_q;
    out_valid_d = out_valid_q;
    res_min_d   = res_min_q;
    res_max_d   = res_max_q;
    res_mean_d  = res_mean_q;
    res_var_d   = res_var_q;

    if (clear) begin
      // abort wins over any accept or handshake in the same cycle
      state_d     = S_ACC;
      cnt_d       = '0;
      sum_d       = '0;
      sumsq_d     = '0;
      run_min_d   = MIN_INIT;
      run_max_d   = MAX_INIT;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_ACC: begin
          if (s.in_valid) begin
            sum_d   = sum_q + SW'(x);
            sumsq_d = sumsq_q + QW'(x_sq);
            if (x < run_min_q) run_min_d = x;
            if (x > run_max_q) run_max_d = x;
            cnt_d = cnt_q + LOG2_LEN'(1);
            // counter wraps to zero on the LEN-th sample
            if (&cnt_q) state_d = S_SQ;
          end
        end
        S_SQ: begin
          sq_d    = $unsigned(sum_ext * sum_ext);
          state_d = S_VAR;
        end
        S_VAR: begin
          res_var_d   = (2*W)'(diff >> (2 * LOG2_LEN));
          res_mean_d  = W'(sum_q >>> LOG2_LEN);
          res_min_d   = run_min_q;
          res_max_d   = run_max_q;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
        S_DONE: begin
          if (s.out_ready) begin
            out_valid_d = 1'b0;
            cnt_d       = '0;
            sum_d       = '0;
            sumsq_d     = '0;
            run_min_d   = MIN_INIT;
            run_max_d   = MAX_INIT;
            state_d     = S_ACC;
          end
        end
        default: state_d = S_ACC;
      endcase
    end
  end

endmodule
